disp_scan: RTL
==============

# disp_scan

Time-multiplexed scan controller sitting directly upstream of the segment decoder in the digital lock's display path. It holds a four-glyph message and steps through the glyphs one at a time, presenting one 4-bit glyph code per scan slot to the decoder. It drives the matching active-low anode strobe and supports tear-free message updates and whole-display blinking.

## Interface
- DIV, 100000: clocks per scan slot (≥2); 1 kHz/slot at 100 MHz.
- BLINK_FRAMES, 125: full 4-slot frames per blink half-period (≥1).
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- msg  in  16  glyph codes; msg[3:0] → slot 0 (an[0], rightmost) … msg[15:12] → slot 3.
- load  in  1  single-cycle strobe: capture msg into shadow register.
- blink_en  in  1  level; when 1, the display alternates visible/blank every BLINK_FRAMES frames.
- digit  out  4  glyph code for the current slot, to the segment decoder.
- an  out  4  active-low anode enables, one-hot-low when visible.
- pending  out  1  shadow message captured, not yet applied.

## Operation
- Glyph codes: A=0, B=1, C=2, L=3, U=4; BLANK=4'hF. Any other code is passed through unchanged; the decoder blanks it.
- Prescaler cnt counts 0..DIV-1 and wraps. tick=1 in the cycle cnt==DIV-1.
- Slot index idx (2 bits) advances on tick, 3→0 wraps. The transition to idx 0 is frame start.
- load: shadow <= msg; pending <= 1. A later load before apply overwrites the shadow (last wins).
- Apply: on a frame-start tick with pending=1, active <= shadow and pending <= 0.
  - If load coincides with the apply, active takes the old shadow and shadow takes the new msg. pending stays 1, so the new message applies at the next frame start.
- Blink: the frame counter fcnt increments on each frame-start tick, wrapping at BLINK_FRAMES-1. On the wrap, phase toggles.
  - blank = blink_en & phase.
  - When blink_en=0, phase and fcnt keep running but have no effect.
- Output update on tick, using post-tick idx, active and phase:
  - If blank: digit <= 4'hF, an <= 4'b1111.
  - Otherwise: digit <= active[4*idx+:4], an <= ~(4'b0001 << idx).
- Between ticks, digit and an hold their values. A blink_en change takes effect at the next tick.

## Timing
- Reset values: cnt=0, idx=3, fcnt=0, phase=0, pending=0, shadow=active=16'hFFFF, digit=4'hF, an=4'b1111.
- First tick after reset is cycle DIV-1 after rst_n deasserts. It is a frame start: idx=0, an=4'b1110, digit=active[3:0].
- digit and an are registered and change together, exactly on the tick edge. Each slot lasts DIV cycles; a frame lasts 4·DIV cycles.
- load → pending=1 on the next edge.
- Load-to-display latency is at most one frame plus one slot, never mid-frame.
- rst_n low mid-frame restores all reset values at the next edge and discards the shadow.

## Structure
- Shared package `lock_disp_pkg`:
  - Glyph constants GLYPH_A..GLYPH_U and GLYPH_BLANK.
  - The package is also imported by the segment decoder, so both blocks use identical encodings.
- Sub-module `tick_gen` (parameter DIV; ports clk, rst_n, tick): prescaler counter with $clog2(DIV)-bit width.
- Scan, apply and blink logic stay in disp_scan.

## Test plan
Use DIV=4 and BLINK_FRAMES=2 unless stated.
- Reset release with no load → first tick at cycle 3: an=1110, digit=F. Over one frame, an walks 1110,1101,1011,0111, every 4 cycles, digit=F throughout.
- load msg=16'h3012 mid-frame → pending=1. At the next frame start, an=1110 with digit=2, then 1,0,3. pending=0.
- Two loads in one frame, 16'h0000 then 16'h4444 → the next frame shows all 4s, never 0.
- load asserted exactly on the frame-start tick edge → that frame shows the old shadow, pending stays 1, and the new message appears the following frame.
- blink_en=1 with msg 16'h0123 applied → 2 frames visible, then 2 frames with an=1111 and digit=F, repeating. blink_en=0 during a blank frame → visible from the next tick.
- rst_n pulsed low for 1 cycle during slot 2 with a pending load → outputs F/1111 and pending=0. Restart timing matches the first scenario.

Source files
------------

// File: rtl/lock_disp_pkg.sv
// lock_disp_pkg: glyph encodings and slot helpers shared by the scan controller and the segment decoder
//
// Contents:
//   GLYPH_A..GLYPH_U, GLYPH_BLANK  4-bit glyph codes understood by the decoder
//   AN_OFF                         all anodes released (active-low)
//   glyph_at(m, i)                 4-bit glyph for slot i out of a 16-bit message
//   anode(i)                       one-hot-low anode pattern for slot i
package lock_disp_pkg;
   localparam logic [3:0] GLYPH_A     = 4'h0;
   localparam logic [3:0] GLYPH_B     = 4'h1;
   localparam logic [3:0] GLYPH_C     = 4'h2;
   localparam logic [3:0] GLYPH_L     = 4'h3;
   localparam logic [3:0] GLYPH_U     = 4'h4;
   localparam logic [3:0] GLYPH_BLANK = 4'hF;
   localparam logic [3:0] AN_OFF      = 4'b1111;

   function automatic logic [3:0] glyph_at(input logic [15:0] m, input logic [1:0] i);
      return m[{i, 2'b00} +: 4];
   endfunction

   function automatic logic [3:0] anode(input logic [1:0] i);
      return ~(4'b0001 << i);
   endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: scan-slot prescaler, pulses tick for one cycle every DIV clocks
//
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset (counter restarts at 0)
//   tick   out  high during the cycle in which the counter sits at DIV-1
module tick_gen #(
   parameter int DIV = 100000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);
   localparam int W = $clog2(DIV);

   logic [W-1:0] cnt;

   always_comb tick = cnt == W'(DIV - 1);

   always_ff @(posedge clk) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= tick ? '0 : cnt + W'(1);
   end
endmodule

// File: rtl/disp_scan.sv
// disp_scan: four-glyph time-multiplexed display scanner with tear-free updates and blinking
//
// Ports:
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   msg       in   four glyph codes, msg[3:0] is slot 0 (rightmost)
//   load      in   single-cycle strobe capturing msg into the shadow register
//   blink_en  in   alternate visible/blank every BLINK_FRAMES frames
//   digit     out  glyph code for the slot currently strobed
//   an        out  active-low anode enables
//   pending   out  shadow message captured but not yet shown
module disp_scan
   import lock_disp_pkg::*;
#(
   parameter int DIV          = 100000,
   parameter int BLINK_FRAMES = 125
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] msg,
   input  logic        load,
   input  logic        blink_en,
   output logic [3:0]  digit,
   output logic [3:0]  an,
   output logic        pending
);
   localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

   logic          tick;
   logic [1:0]    idx;
   logic [1:0]    idx_nx;
   logic [FW-1:0] fcnt;
   logic          phase;
   logic          phase_nx;
   logic          frame_start;
   logic          apply;
   logic          fwrap;
   logic          blank;
   logic [15:0]   shadow;
   logic [15:0]   active;
   logic [15:0]   active_nx;

   tick_gen #(.DIV(DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // The output registers are loaded from post-tick slot, message and phase,
   // so a frame never mixes old and new messages.
   always_comb begin
      idx_nx      = idx + 2'd1;
      frame_start = tick & (idx == 2'd3);
      apply       = frame_start & pending;
      active_nx   = apply ? shadow : active;
      fwrap       = fcnt == FW'(BLINK_FRAMES - 1);
      phase_nx    = phase ^ (frame_start & fwrap);
      blank       = blink_en & phase_nx;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx     <= 2'd3;
         fcnt    <= '0;
         phase   <= 1'b0;
         pending <= 1'b0;
         shadow  <= 16'hFFFF;
         active  <= 16'hFFFF;
         digit   <= GLYPH_BLANK;
         an      <= AN_OFF;
      end else begin
         if (tick) idx <= idx_nx;
         if (frame_start) fcnt <= fwrap ? '0 : fcnt + FW'(1);
         phase  <= phase_nx;
         active <= active_nx;
         if (load) shadow <= msg;
         // A load coinciding with apply re-arms pending for the next frame.
         pending <= load | (pending & ~apply);
         if (tick) begin
            digit <= blank ? GLYPH_BLANK : glyph_at(active_nx, idx_nx);
            an    <= blank ? AN_OFF : anode(idx_nx);
         end
      end
   end
endmodule
